keypad_operand_entry: RTL and testbench

- Sits directly downstream of the keypad scanner/decoder.
- Consumes a decoded 4-bit key code plus a level "key pressed" strobe.
- Assembles two multi-digit BCD operands (A, then B) under FSM control.
- Emits a one-cycle ready pulse when both operands are committed, for the arithmetic/display stage.

---
 rtl/keypad_operand_entry.sv | 145 ++++++++++++++
 tb/tb_keypad_operand_entry.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/keypad_operand_entry.sv
// ============================================================================
// Module   : keypad_operand_entry
// Purpose  : Collects two multi-digit BCD operands (A then B) from a decoded
//            keypad stream and flags the arithmetic stage when both are ready.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module keypad_operand_entry #(
  parameter int         DIGITS    = 3,
  parameter logic [3:0] KEY_ENTER = 4'hB,
  parameter logic [3:0] KEY_CLEAR = 4'hA
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            key_code,
  input  logic                  key_valid,
  output logic [4*DIGITS-1:0]   operand_a,
  output logic [4*DIGITS-1:0]   operand_b,
  output logic [1:0]            entry_state,
  output logic                  operands_ready,
  output logic                  entry_err
);

  localparam int OPW = 4 * DIGITS;
  localparam int CW  = $clog2(DIGITS + 1);

  typedef enum logic [1:0] {
    ENTRY_A = 2'b00,
    ENTRY_B = 2'b01,
    DONE    = 2'b10
  } state_t;

  state_t          r_state;
  logic [OPW-1:0]  r_op_a;
  logic [OPW-1:0]  r_op_b;
  logic [CW-1:0]   r_cnt_a;
  logic [CW-1:0]   r_cnt_b;
  logic            r_kv_q;
  logic            r_ready;
  logic            r_err;

  logic            w_accept;
  logic            w_is_digit;
  logic            w_a_room;
  logic            w_b_room;
  logic [OPW-1:0]  w_code_ext;
  logic [OPW-1:0]  w_shift_a;
  logic [OPW-1:0]  w_shift_b;

  // A key is taken only on the first cycle key_valid is seen high, so a held
  // key produces exactly one action.
  assign w_accept   = key_valid & ~r_kv_q;
  assign w_is_digit = (key_code <= 4'd9);
  assign w_a_room   = (r_cnt_a < CW'(DIGITS));
  assign w_b_room   = (r_cnt_b < CW'(DIGITS));
  assign w_code_ext = OPW'(key_code);

  // Shift form instead of a slice keeps the expression legal for DIGITS = 1.
  assign w_shift_a  = (r_op_a << 4) | w_code_ext;
  assign w_shift_b  = (r_op_b << 4) | w_code_ext;

  // Entry FSM: edge detect, operand assembly and the two registered pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ENTRY_A;
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_cnt_a <= '0;
      r_cnt_b <= '0;
      r_kv_q  <= 1'b0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_kv_q  <= key_valid;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      if (w_accept) begin
        if (key_code == KEY_CLEAR) begin
          // Abort from any state; no pulse is raised for a clear.
          r_state <= ENTRY_A;
          r_op_a  <= '0;
          r_op_b  <= '0;
          r_cnt_a <= '0;
          r_cnt_b <= '0;
        end else if (key_code == KEY_ENTER) begin
          case (r_state)
            ENTRY_A: begin
              if (r_cnt_a != '0) r_state <= ENTRY_B;
              else               r_err   <= 1'b1;
            end
            ENTRY_B: begin
              if (r_cnt_b != '0) begin
                r_state <= DONE;
                r_ready <= 1'b1;
              end else begin
                r_err <= 1'b1;
              end
            end
            default: r_err <= 1'b1;
          endcase
        end else if (w_is_digit) begin
          case (r_state)
            ENTRY_A: begin
              if (w_a_room) begin
                r_op_a  <= w_shift_a;
                r_cnt_a <= r_cnt_a + CW'(1);
              end else begin
                r_err <= 1'b1;
              end
            end
            ENTRY_B: begin
              if (w_b_room) begin
                r_op_b  <= w_shift_b;
                r_cnt_b <= r_cnt_b + CW'(1);
              end else begin
                r_err <= 1'b1;
              end
            end
            default: begin
              // A digit after a finished pair starts a fresh A operand.
              r_state <= ENTRY_A;
              r_op_a  <= w_code_ext;
              r_cnt_a <= CW'(1);
              r_op_b  <= '0;
              r_cnt_b <= '0;
            end
          endcase
        end else begin
          // Unused codes are rejected without touching any state.
          r_err <= 1'b1;
        end
      end
    end
  end

  assign operand_a      = r_op_a;
  assign operand_b      = r_op_b;
  assign entry_state    = r_state;
  assign operands_ready = r_ready;
  assign entry_err      = r_err;

endmodule

`default_nettype wire

// File: tb/tb_keypad_operand_entry.sv
// ============================================================================
// Module   : tb_keypad_operand_entry
// Purpose  : Self-checking bench for keypad_operand_entry (DIGITS = 3).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_keypad_operand_entry;

  logic        clk;
  logic        reset;
  logic [3:0]  key_code;
  logic        key_valid;
  logic [11:0] operand_a;
  logic [11:0] operand_b;
  logic [1:0]  entry_state;
  logic        operands_ready;
  logic        entry_err;

  keypad_operand_entry #(
    .DIGITS    (3),
    .KEY_ENTER (4'hB),
    .KEY_CLEAR (4'hA)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .key_code       (key_code),
    .key_valid      (key_valid),
    .operand_a      (operand_a),
    .operand_b      (operand_b),
    .entry_state    (entry_state),
    .operands_ready (operands_ready),
    .entry_err      (entry_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] a;
    logic [11:0] b;
    logic [1:0]  st;
    logic        rdy;
    logic        err;
  } exp_t;

  typedef struct {
    logic [3:0]  code;
    int          hold;
    int          gap;
    logic [11:0] a;
    logic [11:0] b;
    logic [1:0]  st;
    logic        rdy;
    logic        err;
  } vec_t;

  localparam int NV = 27;
  vec_t tbl [NV];
  exp_t sb [$];

  int   total = 0;
  int   bad   = 0;
  logic kv_prev = 1'b0;
  logic mon_acc = 1'b0;

  task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive one key press; the expected result is queued for the monitor.
  task automatic press(input logic [3:0] code, input int hold, input int gap,
                       input logic [11:0] a, input logic [11:0] b,
                       input logic [1:0] st, input logic rdy, input logic err);
    exp_t e;
    e.a = a; e.b = b; e.st = st; e.rdy = rdy; e.err = err;
    @(posedge clk); #3;
    key_code  = code;
    key_valid = 1'b1;
    sb.push_back(e);
    repeat (hold) @(posedge clk);
    #3 key_valid = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  // Monitor: independently detects acceptances and checks 1 cycle later.
  always @(posedge clk) begin
    if (reset) begin
      kv_prev = 1'b0;
      mon_acc = 1'b0;
    end else begin
      mon_acc = key_valid && !kv_prev;
      kv_prev = key_valid;
    end
    #1;
    if (mon_acc) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_empty: acceptance with no expected entry at %0t", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("op_a",  operand_a, e.a);
        chk("op_b",  operand_b, e.b);
        chk("state", 12'(entry_state), 12'(e.st));
        chk("ready", 12'(operands_ready), 12'(e.rdy));
        chk("err",   12'(entry_err), 12'(e.err));
      end
    end else if (!reset) begin
      chk("idle_ready", 12'(operands_ready), 12'h0);
      chk("idle_err",   12'(entry_err), 12'h0);
    end
  end

  initial begin
    // code hold gap  A       B       st    rdy  err
    tbl[0]  = '{4'h1, 5, 3, 12'h001, 12'h000, 2'b00, 1'b0, 1'b0};
    tbl[1]  = '{4'h2, 5, 3, 12'h012, 12'h000, 2'b00, 1'b0, 1'b0};
    tbl[2]  = '{4'h3, 5, 3, 12'h123, 12'h000, 2'b00, 1'b0, 1'b0};
    tbl[3]  = '{4'hB, 2, 2, 12'h123, 12'h000, 2'b01, 1'b0, 1'b0};
    tbl[4]  = '{4'h4, 3, 1, 12'h123, 12'h004, 2'b01, 1'b0, 1'b0};
    tbl[5]  = '{4'h5, 1, 1, 12'h123, 12'h045, 2'b01, 1'b0, 1'b0};
    tbl[6]  = '{4'hB, 2, 2, 12'h123, 12'h045, 2'b10, 1'b1, 1'b0};
    tbl[7]  = '{4'hB, 2, 2, 12'h123, 12'h045, 2'b10, 1'b0, 1'b1};
    tbl[8]  = '{4'h5, 2, 2, 12'h005, 12'h000, 2'b00, 1'b0, 1'b0};
    tbl[9]  = '{4'h6, 2, 2, 12'h056, 12'h000, 2'b00, 1'b0, 1'b0};
    tbl[10] = '{4'hA, 2, 2, 12'h000, 12'h000, 2'b00, 1'b0, 1'b0};
    tbl[11] = '{4'hB, 2, 2, 12'h000, 12'h000, 2'b00, 1'b0, 1'b1};
    tbl[12] = '{4'h9, 2, 2, 12'h009, 12'h000, 2'b00, 1'b0, 1'b0};
    tbl[13] = '{4'h8, 2, 2, 12'h098, 12'h000, 2'b00, 1'b0, 1'b0};
    tbl[14] = '{4'h7, 2, 2, 12'h987, 12'h000, 2'b00, 1'b0, 1'b0};
    tbl[15] = '{4'h6, 2, 2, 12'h987, 12'h000, 2'b00, 1'b0, 1'b1};
    tbl[16] = '{4'hB, 2, 2, 12'h987, 12'h000, 2'b01, 1'b0, 1'b0};
    tbl[17] = '{4'hE, 2, 2, 12'h987, 12'h000, 2'b01, 1'b0, 1'b1};
    tbl[18] = '{4'hB, 2, 2, 12'h987, 12'h000, 2'b01, 1'b0, 1'b1};
    tbl[19] = '{4'hC, 2, 2, 12'h987, 12'h000, 2'b01, 1'b0, 1'b1};
    tbl[20] = '{4'h1, 2, 2, 12'h987, 12'h001, 2'b01, 1'b0, 1'b0};
    tbl[21] = '{4'h2, 2, 2, 12'h987, 12'h012, 2'b01, 1'b0, 1'b0};
    tbl[22] = '{4'h3, 2, 2, 12'h987, 12'h123, 2'b01, 1'b0, 1'b0};
    tbl[23] = '{4'h4, 2, 2, 12'h987, 12'h123, 2'b01, 1'b0, 1'b1};
    tbl[24] = '{4'hB, 2, 2, 12'h987, 12'h123, 2'b10, 1'b1, 1'b0};
    tbl[25] = '{4'hF, 2, 2, 12'h987, 12'h123, 2'b10, 1'b0, 1'b1};
    tbl[26] = '{4'hA, 2, 2, 12'h000, 12'h000, 2'b00, 1'b0, 1'b0};

    reset     = 1'b1;
    key_code  = 4'h0;
    key_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_a",     operand_a, 12'h000);
    chk("rst_b",     operand_b, 12'h000);
    chk("rst_state", 12'(entry_state), 12'h0);
    chk("rst_ready", 12'(operands_ready), 12'h0);
    chk("rst_err",   12'(entry_err), 12'h0);

    for (int i = 0; i < NV; i++)
      press(tbl[i].code, tbl[i].hold, tbl[i].gap,
            tbl[i].a, tbl[i].b, tbl[i].st, tbl[i].rdy, tbl[i].err);

    // Long hold: a single acceptance, counter advanced by exactly one.
    press(4'h7, 200, 3, 12'h007, 12'h000, 2'b00, 1'b0, 1'b0);
    #1;
    chk("hold_a", operand_a, 12'h007);
    press(4'h1, 2, 2, 12'h071, 12'h000, 2'b00, 1'b0, 1'b0);
    press(4'h2, 2, 2, 12'h712, 12'h000, 2'b00, 1'b0, 1'b0);
    press(4'h3, 2, 2, 12'h712, 12'h000, 2'b00, 1'b0, 1'b1);

    // Asynchronous reset in ENTRY_B with A = 012, key held across release.
    press(4'hA, 2, 2, 12'h000, 12'h000, 2'b00, 1'b0, 1'b0);
    press(4'h1, 2, 2, 12'h001, 12'h000, 2'b00, 1'b0, 1'b0);
    press(4'h2, 2, 2, 12'h012, 12'h000, 2'b00, 1'b0, 1'b0);
    press(4'hB, 2, 2, 12'h012, 12'h000, 2'b01, 1'b0, 1'b0);
    press(4'h3, 2, 2, 12'h012, 12'h003, 2'b01, 1'b0, 1'b0);
    @(posedge clk); #3;
    reset = 1'b1;
    #2;
    chk("arst_a",     operand_a, 12'h000);
    chk("arst_b",     operand_b, 12'h000);
    chk("arst_state", 12'(entry_state), 12'h0);
    chk("arst_ready", 12'(operands_ready), 12'h0);
    chk("arst_err",   12'(entry_err), 12'h0);
    key_code  = 4'h5;
    key_valid = 1'b1;
    @(posedge clk); #3;
    begin
      exp_t e;
      e.a = 12'h005; e.b = 12'h000; e.st = 2'b00; e.rdy = 1'b0; e.err = 1'b0;
      sb.push_back(e);
    end
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #3 key_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;

    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover: %0d expected entries never matched, required 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
